// File: rtl/gpio_disp_pkg.sv
// rtl/gpio_disp_pkg.sv - shared types and constants for the GPIO BCD display
package gpio_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int NDIGITS_DEFAULT = 8;
    localparam int BCD_NIBBLES     = 10;

    // Active-low segments, bit0 = a ... bit6 = g, indexed by nibble value.
    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpio_bcd_display_if.sv
// rtl/gpio_bcd_display_if.sv - GPIO word in, seven-segment drives and status out
interface gpio_bcd_display_if;
    logic [31:0] value;
    logic        mode;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy;
    logic        ovf;

    modport master (
        output value, mode,
        input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, ovf
    );

    modport slave (
        input  value, mode,
        output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, ovf
    );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational nibble to active-low seven-segment decoder
module seg7_encode
    import gpio_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/gpio_bcd_display.sv
// rtl/gpio_bcd_display.sv - GPIO word to decimal (double-dabble) or hex seven-segment display
module gpio_bcd_display
    import gpio_disp_pkg::*;
#(
    parameter int NDIGITS   = NDIGITS_DEFAULT,
    parameter int CONV_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    gpio_bcd_display_if.slave bus
);

    localparam int BCD_W     = 4 * BCD_NIBBLES;
    localparam int OP_EXT_W  = max_int(CONV_BITS, 4 * NDIGITS);
    localparam int BCD_EXT_W = max_int(BCD_W, 4 * NDIGITS);
    localparam int SLOTS     = max_int(8, NDIGITS);

    state_t                     state, state_next;
    logic [5:0]                 cnt;
    logic [CONV_BITS-1:0]       op;
    logic [BCD_W-1:0]           bcd;
    logic                       work_mode;
    logic [31:0]                last_value;
    logic                       last_mode;
    logic [NDIGITS-1:0][3:0]    disp;
    logic                       ovf_q;

    logic                       change;
    logic [BCD_W-1:0]           bcd_adj;
    logic [BCD_W+CONV_BITS-1:0] shifted;
    logic [OP_EXT_W-1:0]        op_ext;
    logic [BCD_EXT_W-1:0]       bcd_ext;
    logic [NDIGITS-1:0][3:0]    dec_nibs;
    logic [NDIGITS-1:0][3:0]    hex_nibs;
    logic                       dec_ovf;

    assign change = (bus.value != last_value) || (bus.mode != last_mode);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (change) state_next = bus.mode ? LATCH : SHIFT;
            SHIFT:   if (cnt == 6'(CONV_BITS - 1)) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble step: correct every nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_NIBBLES; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {bcd_adj, op} << 1;

    assign op_ext  = OP_EXT_W'(op);
    assign bcd_ext = BCD_EXT_W'(bcd);
    assign dec_ovf = |(bcd_ext >> (4 * NDIGITS));

    always_comb begin
        dec_nibs = '0;
        hex_nibs = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            dec_nibs[k] = bcd_ext[4*k +: 4];
            hex_nibs[k] = op_ext[4*k +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            bcd        <= '0;
            work_mode  <= 1'b0;
            last_value <= '0;
            last_mode  <= 1'b0;
            disp       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (change) begin
                        op         <= CONV_BITS'(bus.value);
                        bcd        <= '0;
                        work_mode  <= bus.mode;
                        last_value <= bus.value;
                        last_mode  <= bus.mode;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    bcd <= shifted[BCD_W+CONV_BITS-1 : CONV_BITS];
                    op  <= shifted[CONV_BITS-1:0];
                    cnt <= cnt + 6'd1;
                end
                LATCH: begin
                    disp  <= work_mode ? hex_nibs : dec_nibs;
                    ovf_q <= !work_mode && dec_ovf;
                end
                default: ;
            endcase
        end
    end

    // Decode sits after the nibble registers so the outputs only move on LATCH.
    logic [SLOTS-1:0][6:0] segs;

    for (genvar k = 0; k < SLOTS; k++) begin : g_digit
        if (k < NDIGITS) begin : g_enc
            seg7_encode u_enc (
                .nibble (disp[k]),
                .seg    (segs[k])
            );
        end else begin : g_blank
            assign segs[k] = 7'h7F;
        end
    end

    assign bus.hex0 = segs[0];
    assign bus.hex1 = segs[1];
    assign bus.hex2 = segs[2];
    assign bus.hex3 = segs[3];
    assign bus.hex4 = segs[4];
    assign bus.hex5 = segs[5];
    assign bus.hex6 = segs[6];
    assign bus.hex7 = segs[7];
    assign bus.busy = (state != IDLE);
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_gpio_bcd_display.sv
// tb/tb_gpio_bcd_display.sv - self-checking bench for gpio_bcd_display
module tb_gpio_bcd_display;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gpio_bcd_display_if bus_i ();

    gpio_bcd_display #(
        .NDIGITS   (8),
        .CONV_BITS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    wire [55:0] disp_word = {bus_i.hex7, bus_i.hex6, bus_i.hex5, bus_i.hex4,
                             bus_i.hex3, bus_i.hex2, bus_i.hex1, bus_i.hex0};

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [55:0] cur_word;
    logic        cur_ovf;
    logic [31:0] last_v;
    logic        last_m;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // {ovf, hex7..hex0} the display should show for a given word and mode.
    function automatic logic [56:0] model(input logic [31:0] v, input logic m);
        logic [55:0]     w;
        longint unsigned d;
        int              nib;
        w = '0;
        d = longint'(v) % 100000000;
        for (int k = 0; k < 8; k++) begin
            if (m) begin
                nib = int'((v >> (4 * k)) & 32'hF);
            end else begin
                nib = int'(d % 10);
                d   = d / 10;
            end
            w[7*k +: 7] = seg_of(nib);
        end
        return {(!m && (longint'(v) >= 100000000)), w};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts busy cycles from the next falling edge and notes any display movement meanwhile.
    task automatic wait_idle(output int cycles, output int held_bad);
        cycles   = 0;
        held_bad = 0;
        @(negedge clk);
        while (bus_i.busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (disp_word !== cur_word || bus_i.ovf !== cur_ovf) held_bad++;
            @(negedge clk);
        end
    endtask

    task automatic finish_conv(input string tag, input logic [31:0] v, input logic m,
                               input int cyc, input int bad, input int exp_cyc);
        logic [56:0] e;
        e = model(v, m);
        check({tag, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " held"}, 64'(bad), 64'd0);
        check({tag, " display"}, 64'(disp_word), 64'(e[55:0]));
        check({tag, " ovf"}, 64'(bus_i.ovf), 64'(e[56]));
        check({tag, " busy idle"}, 64'(bus_i.busy), 64'd0);
        cur_word = e[55:0];
        cur_ovf  = e[56];
        last_v   = v;
        last_m   = m;
    endtask

    task automatic run_conv(input string tag, input logic [31:0] v, input logic m);
        int cyc, bad;
        bus_i.value = v;
        bus_i.mode  = m;
        wait_idle(cyc, bad);
        finish_conv(tag, v, m, cyc, bad, m ? 1 : 33);
    endtask

    initial begin
        logic [56:0] z;
        logic [31:0] rv;
        logic        rm;
        int          cyc, bad, busy_seen;

        bus_i.value = '0;
        bus_i.mode  = 1'b0;
        z = model(32'd0, 1'b0);

        // Reset held for two rising edges.
        @(negedge clk);
        @(negedge clk);
        check("reset display", 64'(disp_word), 64'(z[55:0]));
        check("reset busy", 64'(bus_i.busy), 64'd0);
        check("reset ovf", 64'(bus_i.ovf), 64'd0);
        rst = 1'b0;
        cur_word = z[55:0];
        cur_ovf  = 1'b0;
        last_v   = '0;
        last_m   = 1'b0;

        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_i.busy !== 1'b0) busy_seen++;
        end
        check("idle after reset busy", 64'(busy_seen), 64'd0);
        check("idle after reset display", 64'(disp_word), 64'(z[55:0]));

        run_conv("dec 12345678", 32'd12345678, 1'b0);
        run_conv("dec ffffffff", 32'hFFFF_FFFF, 1'b0);
        run_conv("dec 99999999", 32'd99999999, 1'b0);
        run_conv("dec 100000000", 32'd100000000, 1'b0);
        run_conv("hex deadbeef", 32'hDEAD_BEEF, 1'b1);
        run_conv("hex zero", 32'd0, 1'b1);
        run_conv("dec zero", 32'd0, 1'b0);

        // A change mid-SHIFT is deferred until IDLE, then converted once.
        bus_i.value = 32'd5;
        bus_i.mode  = 1'b0;
        repeat (5) @(negedge clk);
        check("retrigger busy mid", 64'(bus_i.busy), 64'd1);
        bus_i.value = 32'd7;
        wait_idle(cyc, bad);
        finish_conv("retrigger first", 32'd5, 1'b0, cyc, bad, 28);
        wait_idle(cyc, bad);
        finish_conv("retrigger second", 32'd7, 1'b0, cyc, bad, 33);

        // Reset during SHIFT abandons the conversion; the unchanged input then reconverts.
        bus_i.value = 32'd99;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset display", 64'(disp_word), 64'(z[55:0]));
        check("midreset busy", 64'(bus_i.busy), 64'd0);
        check("midreset ovf", 64'(bus_i.ovf), 64'd0);
        cur_word = z[55:0];
        cur_ovf  = 1'b0;
        wait_idle(cyc, bad);
        finish_conv("midreset reconvert", 32'd99, 1'b0, cyc, bad, 33);

        for (int i = 0; i < 24; i++) begin
            rv = $urandom;
            if ($urandom_range(0, 2) == 0) rv = 32'($urandom_range(0, 999));
            rm = 1'($urandom_range(0, 1));
            if (rv == last_v && rm == last_m) rv = rv ^ 32'h1;
            run_conv("random", rv, rm);
        end

        // Mode-only change on the same word.
        run_conv("mode flip", last_v, !last_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bcd_display.md
GPIO_BCD_DISPLAY -- requirements
Module: gpio_bcd_display

Interface
REQ-001 Parameter NDIGITS, default 8, is the number of seven-segment digits driven.
REQ-002 Parameter CONV_BITS, default 32, is the operand width converted.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 value  input  32  is the CPU GPIO output word to display.
REQ-006 mode  input  1  selects the display format: 0 = decimal, 1 = raw hexadecimal.
REQ-007 hex0..hex7  output  7 each  are the active-low segment drives: bit0 = a ... bit6 = g; hex0 is the least-significant digit.
REQ-008 busy  output  1  is high while a conversion is in progress.
REQ-009 ovf  output  1  is high when the displayed decimal value is truncated, i.e. value >= 100_000_000 in decimal mode.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT and LATCH.
REQ-011 IDLE: when value != last_value or mode != last_mode, the block SHALL capture value and mode into the working registers and into last_value and last_mode.
REQ-012 On such a capture, the next state SHALL be SHIFT if mode = 0, or LATCH if mode = 1.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle: add 3 to each of the 10 BCD nibbles that is >= 5, then shift {bcd, operand} left one bit.
REQ-014 SHIFT SHALL perform exactly CONV_BITS iterations, counted by a 6-bit counter, and then go to LATCH.
REQ-015 LATCH, one cycle, SHALL update the display registers and ovf, then return to IDLE.
  - Decimal mode: the display shows BCD nibbles 0..7; ovf is set when nibble 8 or nibble 9 is nonzero.
  - Hex mode: the display shows value[4k+3:4k] on digit k; ovf = 0.
REQ-016 Latency, measured from the clock edge that captures a change (cycle N): in decimal mode the outputs SHALL change at edge N+33; in hex mode at edge N+1.
REQ-017 busy SHALL be high in SHIFT and LATCH and low in IDLE.
REQ-018 Changes to value or mode during SHIFT or LATCH SHALL be ignored until the FSM returns to IDLE.
  - In IDLE the new value is then compared against last_value, so a final mismatch triggers exactly one reconversion.
REQ-019 The display outputs SHALL hold their previous values throughout a conversion; no intermediate digits appear.
REQ-020 Segment encoding: 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000, A = 7'b0001000, B = 7'b0000011, C = 7'b1000110, D = 7'b0100001, E = 7'b0000110, F = 7'b0001110.
REQ-021 If value equals 0 in both modes, the display SHALL show all '0'.

Reset
REQ-022 While rst = 1 at a clock edge, the block SHALL set the following, regardless of state:
  - state = IDLE, counter = 0, busy = 0, ovf = 0;
  - last_value = 0, last_mode = 0;
  - every digit = 7'b1000000.
REQ-023 A reset asserted during SHIFT SHALL abandon the conversion, with no partial result displayed.
REQ-024 After reset, value = 0 with mode = 0 SHALL cause no conversion.

Structure
REQ-025 Package gpio_disp_pkg SHALL hold the state enum, the 16-entry segment constant table and the NDIGITS default.
REQ-026 Sub-module seg7_encode, combinational (4-bit nibble in, 7-bit active-low segments out), SHALL be instantiated NDIGITS times.
REQ-027 The display registers SHALL hold nibbles; segment decode follows the registers.

Verification
REQ-028 Assert rst for 2 cycles -> all hex = 7'b1000000, busy = 0, ovf = 0; value held at 0 -> busy stays 0 for 50 cycles.
REQ-029 mode = 0, value = 12345678 -> busy high for 33 cycles; at N+33, hex7..hex0 show 1,2,3,4,5,6,7,8 and ovf = 0.
REQ-030 mode = 0, value = 32'hFFFF_FFFF -> display 94967295, ovf = 1.
REQ-031 mode = 1, value = 32'hDEADBEEF -> at N+1, hex7..hex0 show D,E,A,D,B,E,E,F and ovf = 0.
REQ-032 value = 5, then value = 7 five cycles later (mid-SHIFT) -> display 00000005 first, busy drops for exactly 1 cycle, then a second conversion yields 00000007.
REQ-033 value = 99 and rst pulsed 1 cycle at SHIFT iteration 10 -> display all 0, busy = 0 the cycle after; with value still 99, a new conversion starts immediately and ends with display 00000099.
